// File: rtl/ds_ctrl_pkg.sv
// Shared types and default timing constants for data-synchronizer channel controllers.
// No logic: enum, counter width and default hold/gap lengths only.
// Backpressure: not applicable.
package ds_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } ds_state_e;

    localparam int CNT_W           = 4;
    localparam int DEF_HOLD_CYCLES = 3;
    localparam int DEF_GAP_CYCLES  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner pick: first set request at or above ptr, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; caller decides when a winner is consumed and moves ptr.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any_vld
);

    always_comb begin
        int j;
        win_oh  = '0;
        win_idx = '0;
        any_vld = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_vld && req_vec[j]) begin
                any_vld   = 1'b1;
                win_idx   = IW'(j);
                win_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ds_tx_arbiter.sv
// Shares one data-synchronizer channel among NUM_REQ requesters, round-robin.
// Latency: grant/payload/enable registered on the edge that sees a request in IDLE.
// Backpressure: requests are ignored while a transfer holds or gaps the channel.
module ds_tx_arbiter
    import ds_ctrl_pkg::*;
#(
    parameter int  DATA_WIDTH  = 8,
    parameter int  NUM_REQ     = 4,
    parameter int  HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int  GAP_CYCLES  = DEF_GAP_CYCLES,
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [IW-1:0]                 grant_id,
    output logic [DATA_WIDTH-1:0]         unsync_bus,
    output logic                          bus_enable,
    output logic                          busy
);

    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("ds_tx_arbiter: HOLD_CYCLES must be within 2..15");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("ds_tx_arbiter: GAP_CYCLES must be within 1..15");
    end
    if (NUM_REQ < 2) begin : g_bad_num
        $error("ds_tx_arbiter: NUM_REQ must be at least 2");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(NUM_REQ - 1);

    ds_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] bus_q, bus_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    win_oh;
    logic [IW-1:0]         win_idx;
    logic                  any_vld;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_vec (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_vld (any_vld)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_d    = '0;
        grant_id_d = grant_id_q;
        bus_d      = bus_q;
        en_d       = en_q;
        unique case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d    = HOLD;
                    cnt_d      = '0;
                    grant_d    = win_oh;
                    grant_id_d = win_idx;
                    bus_d      = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    en_d       = 1'b1;
                    ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase
        // busy is registered, so it follows the state being entered
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            bus_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            bus_q      <= bus_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign busy       = busy_q;

endmodule
